// File: rtl/mode_select_controller_pkg.sv
// Shared mode encodings, LED mapping and pulse bundle for mode_select_controller.
// Replaces the mode_select_defines.vh header with a package.
package mode_select_controller_pkg;

  typedef enum logic [2:0] {
    MODE_RESET   = 3'd0,
    MODE_NEXT    = 3'd1,
    MODE_REWIND  = 3'd2,
    MODE_FF      = 3'd3,
    MODE_DISPLAY = 3'd4
  } mode_e;

  localparam mode_e MODE_HOME = MODE_NEXT;
  localparam int    NUM_MODES = 5;

  typedef struct packed {
    logic soft_reset;
    logic next;
    logic rewind;
    logic ff;
    logic display;
  } pulse_t;

  function automatic logic [NUM_MODES-1:0] mode_onehot(input mode_e m);
    logic [NUM_MODES-1:0] oh;
    oh = '0;
    if (m <= MODE_DISPLAY) oh[m] = 1'b1;
    return oh;
  endfunction

  function automatic mode_e mode_advance(input mode_e m);
    logic [2:0] nxt;
    nxt = m;
    if (m == MODE_DISPLAY) nxt = MODE_RESET;
    else                   nxt = nxt + 3'd1;
    return mode_e'(nxt);
  endfunction

endpackage

// File: rtl/mode_select_controller_if.sv
// Button-side inputs and player-side outputs of the mode select controller.
interface mode_select_controller_if;
  import mode_select_controller_pkg::*;

  logic                 control_pulse;
  logic                 action_pulse;
  logic                 action_level;
  logic [2:0]           mode;
  logic [NUM_MODES-1:0] mode_leds;
  logic                 soft_reset;
  logic                 next_pulse;
  logic                 rewind_pulse;
  logic                 ff_pulse;
  logic                 display_pulse;

  modport master (
    output control_pulse, action_pulse, action_level,
    input  mode, mode_leds, soft_reset, next_pulse, rewind_pulse, ff_pulse, display_pulse
  );

  modport slave (
    input  control_pulse, action_pulse, action_level,
    output mode, mode_leds, soft_reset, next_pulse, rewind_pulse, ff_pulse, display_pulse
  );

endinterface

// File: rtl/mode_select_controller_hold_timer.sv
// Saturating up-counter with clear and enable; term_o flags the single cycle
// in which an enabled count sits at LIMIT-1.
module hold_timer #(
  parameter int TIMER_W = 32,
  parameter int LIMIT   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [TIMER_W-1:0] TermCount = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Counting continues past the terminal value so the flag cannot repeat,
  // but stops at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i)                    count_d = '0;
    else if (en_i && count_q != '1) count_d = count_q + TIMER_W'(1);
  end

  assign term_o = en_i && !clear_i && (count_q == TermCount);

endmodule

// File: rtl/mode_select_controller.sv
// Routes the shared action button to one of five functions chosen by the control button.
// Optional idle return-to-home is enabled by defining MODE_TIMEOUT_EN.
module mode_select_controller
  import mode_select_controller_pkg::*;
#(
  parameter int TIMER_W           = 32,
  parameter int RESET_HOLD_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES    = 500_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  mode_select_controller_if.slave  bus
);

  mode_e                mode_q, mode_d;
  logic [NUM_MODES-1:0] leds_q, leds_d;
  pulse_t               pulse_q, pulse_d;
  logic                 hold_latch_q, hold_latch_d;

  logic mode_legal;
  logic hold_en;
  logic hold_clear;
  logic hold_term;
  logic idle_term;

  assign mode_legal = (mode_q <= MODE_DISPLAY);
  assign hold_en    = (mode_q == MODE_RESET) && bus.action_level;
  assign hold_clear = !hold_en || bus.control_pulse;

  hold_timer #(
    .TIMER_W (TIMER_W),
    .LIMIT   (RESET_HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (hold_clear),
    .en_i    (hold_en),
    .term_o  (hold_term)
  );

`ifdef MODE_TIMEOUT_EN
  logic idle_clear;

  // Sitting at home is never "idle"; any button activity restarts the count.
  assign idle_clear = bus.control_pulse || bus.action_pulse || bus.action_level ||
                      (mode_q == MODE_HOME);

  hold_timer #(
    .TIMER_W (TIMER_W),
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (idle_clear),
    .en_i    (1'b1),
    .term_o  (idle_term)
  );
`else
  assign idle_term = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_HOME;
      leds_q       <= mode_onehot(MODE_HOME);
      pulse_q      <= '0;
      hold_latch_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      leds_q       <= leds_d;
      pulse_q      <= pulse_d;
      hold_latch_q <= hold_latch_d;
    end
  end

  // Actions decode against the current mode, so a coincident control press
  // still delivers the action to the mode being left.
  always_comb begin
    mode_d       = mode_q;
    pulse_d      = '0;
    hold_latch_d = hold_latch_q;

    if (!mode_legal)            mode_d = MODE_HOME;
    else if (bus.control_pulse) mode_d = mode_advance(mode_q);
    else if (idle_term)         mode_d = MODE_HOME;

    if (bus.action_pulse) begin
      case (mode_q)
        MODE_NEXT:    pulse_d.next    = 1'b1;
        MODE_REWIND:  pulse_d.rewind  = 1'b1;
        MODE_FF:      pulse_d.ff      = 1'b1;
        MODE_DISPLAY: pulse_d.display = 1'b1;
        default:      ;
      endcase
    end

    pulse_d.soft_reset = hold_term && !hold_latch_q;

    if (!bus.action_level) hold_latch_d = 1'b0;
    else if (hold_term)    hold_latch_d = 1'b1;

    leds_d = mode_onehot(mode_d);
  end

  assign bus.mode          = mode_q;
  assign bus.mode_leds     = leds_q;
  assign bus.soft_reset    = pulse_q.soft_reset;
  assign bus.next_pulse    = pulse_q.next;
  assign bus.rewind_pulse  = pulse_q.rewind;
  assign bus.ff_pulse      = pulse_q.ff;
  assign bus.display_pulse = pulse_q.display;

endmodule

// File: tb/tb_mode_select_controller.sv
// Directed bench for mode_select_controller: vector table plus hold, timeout,
// illegal-mode and async-reset sequences.
module tb_mode_select_controller;
  import mode_select_controller_pkg::*;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_SOFT = 5'b10000;
  localparam logic [4:0] P_NEXT = 5'b01000;
  localparam logic [4:0] P_REW  = 5'b00100;
  localparam logic [4:0] P_FF   = 5'b00010;
  localparam logic [4:0] P_DISP = 5'b00001;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mode_select_controller_if bus();

  mode_select_controller #(
    .TIMER_W           (32),
    .RESET_HOLD_CYCLES (8),
    .TIMEOUT_CYCLES    (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ctrl;
    logic       act;
    logic       lvl;
    logic [2:0] expMode;
    logic [4:0] expPulse;
  } vec_t;

  vec_t vecs [28];

  function automatic logic [4:0] ledModel(input logic [2:0] m);
    logic [4:0] oh;
    oh = 5'b00000;
    if (m < 3'd5) oh = 5'b00001 << m;
    return oh;
  endfunction

  function automatic logic [4:0] pulsesNow();
    return {bus.soft_reset, bus.next_pulse, bus.rewind_pulse, bus.ff_pulse, bus.display_pulse};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [2:0] expMode, input logic [4:0] expPulse);
    checkOutput({tag, ".mode"}, {5'b0, bus.mode}, {5'b0, expMode});
    checkOutput({tag, ".leds"}, {3'b0, bus.mode_leds}, {3'b0, ledModel(expMode)});
    checkOutput({tag, ".pulses"}, {3'b0, pulsesNow()}, {3'b0, expPulse});
  endtask

  // Called on a negedge: drive inputs, let one posedge consume them, return on the next negedge.
  task automatic applyStimulus(input logic ctrl, input logic act, input logic lvl);
    bus.control_pulse = ctrl;
    bus.action_pulse  = act;
    bus.action_level  = lvl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd2, P_NONE};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd2, P_NONE};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'd2, P_NONE};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd3, P_NONE};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd3, P_NONE};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd3, P_NONE};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd4, P_NONE};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'd4, P_NONE};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd4, P_NONE};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, P_NONE};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, P_NONE};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd0, P_NONE};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 3'd1, P_NONE};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 3'd1, P_NEXT};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 3'd1, P_NONE};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 3'd2, P_NONE};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 3'd2, P_REW};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 3'd2, P_NONE};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 3'd3, P_NONE};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 3'd3, P_FF};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 3'd3, P_NONE};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 3'd4, P_NONE};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 3'd4, P_DISP};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 3'd4, P_NONE};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 3'd0, P_DISP};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 3'd0, P_NONE};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 3'd0, P_NONE};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 3'd0, P_NONE};

    reset             = 1'b1;
    bus.control_pulse = 1'b0;
    bus.action_pulse  = 1'b0;
    bus.action_level  = 1'b0;
    #12;
    checkState("reset", 3'd1, P_NONE);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("post_reset", 3'd1, P_NONE);

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].act, vecs[i].lvl);
      checkState($sformatf("vec%0d", i), vecs[i].expMode, vecs[i].expPulse);
    end

    // Hold-to-reset in mode 0: a 7-cycle hold is too short, then one pulse on the 8th.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkState($sformatf("short_hold%0d", i), 3'd0, P_NONE);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("hold_release", 3'd0, P_NONE);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkState($sformatf("long_hold%0d", i), 3'd0, (i == 8) ? P_SOFT : P_NONE);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("long_release", 3'd0, P_NONE);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("to_home", 3'd1, P_NONE);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("to_rewind", 3'd2, P_NONE);
`ifdef MODE_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkState($sformatf("idle%0d", k), (k < 20) ? 3'd2 : 3'd1, P_NONE);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("to_rewind2", 3'd2, P_NONE);
    for (int k = 1; k <= 19; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkState($sformatf("idle_b%0d", k), 3'd2, P_NONE);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("ctrl_at_terminal", 3'd3, P_NONE);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("after_terminal", 3'd3, P_NONE);
`else
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkState($sformatf("persist%0d", k), 3'd2, P_NONE);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("to_ff", 3'd3, P_NONE);
`endif

    // Illegal encoding with an action press present: no pulse, then home.
    force dut.mode_q = mode_e'(3'd6);
    bus.action_pulse = 1'b1;
    @(posedge clk);
    #1;
    release dut.mode_q;
    bus.action_pulse = 1'b0;
    @(negedge clk);
    checkOutput("illegal.pulses", {3'b0, pulsesNow()}, {3'b0, P_NONE});
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("illegal_recover", 3'd1, P_NONE);

    // Async reset in the middle of a hold.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkState($sformatf("walk%0d", i), (i == 3) ? 3'd0 : 3'(i + 2), P_NONE);
    end
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkState($sformatf("mid_hold%0d", i), 3'd0, P_NONE);
    end
    reset = 1'b1;
    #1;
    checkState("async_reset", 3'd1, P_NONE);
    @(posedge clk);
    @(negedge clk);
    checkState("in_reset", 3'd1, P_NONE);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("after_reset", 3'd1, P_NONE);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkState("back_to_reset_mode", 3'd0, P_NONE);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkState($sformatf("rehold%0d", i), 3'd0, (i == 8) ? P_SOFT : P_NONE);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("rehold_release", 3'd0, P_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_select_controller.md
Name: mode_select_controller

Overview:
- Sequential replacement for the combinational button-routing FSM in the top level.
- Shares the single action button between five functions: soft reset, next song, rewind, fast-forward and display toggle.
- The control button cycles through the modes. The action button produces a registered one-cycle pulse to the function of the currently selected mode.
- Sits between the button_press_unit instances and music_player / wave_display_top. Adds hold-to-reset protection and an inactivity timeout.

Parameters:
- TIMER_W, 32, width of the internal hold and idle counters.
- RESET_HOLD_CYCLES, 100_000_000, consecutive cycles action_level must stay high in MODE_RESET before soft_reset fires (1 s at 100 MHz).
- TIMEOUT_CYCLES, 500_000_000, idle cycles outside the home mode before the mode returns home (5 s at 100 MHz).

Ports:
- clk  input  1  100 MHz system clock (clk_100 domain).
- reset  input  1  asynchronous, active-high reset.
- control_pulse  input  1  one-cycle pulse from the control button's button_press_unit.
- action_pulse  input  1  one-cycle pulse from the action button's button_press_unit.
- action_level  input  1  synchronized, debounced level of the action button.
- mode  output  3  current mode encoding.
- mode_leds  output  5  one-hot copy of mode; bit n is high when mode == n.
- soft_reset  output  1  one-cycle reset request.
- next_pulse  output  1  one-cycle pulse to the music player's next input.
- rewind_pulse  output  1  one-cycle pulse to the rewind input.
- ff_pulse  output  1  one-cycle pulse to the fast-forward input.
- display_pulse  output  1  one-cycle pulse to the display toggle.

Behaviour:
- Modes: MODE_RESET=0, MODE_NEXT=1, MODE_REWIND=2, MODE_FF=3, MODE_DISPLAY=4. HOME is MODE_NEXT.
- On async reset: mode=HOME, mode_leds=5'b00010, all pulse outputs 0, both counters 0, hold latch cleared.
- Mode transitions:
  - control_pulse advances mode by +1, wrapping 4 -> 0; the new mode is visible the next cycle.
  - Encodings 5-7 are illegal: the next cycle forces HOME, and no pulses are issued while the illegal value is present.
- Action pulses:
  - action_pulse in MODE_NEXT, MODE_REWIND, MODE_FF or MODE_DISPLAY asserts the matching output for exactly one cycle, one cycle after the input (latency 1, registered).
  - action_pulse in MODE_RESET produces no output.
  - At most one pulse output is high in any cycle.
- Simultaneous control_pulse and action_pulse: the action is decoded against the mode before the advance, then the mode advances.
- Hold-to-reset:
  - In MODE_RESET, the hold counter increments each cycle action_level=1 and clears when action_level=0 or the mode changes.
  - When the count reaches RESET_HOLD_CYCLES-1, soft_reset is high for exactly one cycle and the hold latch sets.
  - While the latch is set, no further soft_reset fires; the latch clears on action_level=0.
  - The hold counter saturates; it never wraps.
  - soft_reset does not change mode. The top level ORs it into the system reset, and the consequent async reset returns mode to HOME.
- Idle timeout (MODE_TIMEOUT_EN only):
  - The idle counter clears on any control_pulse, action_pulse or action_level=1, and also while mode==HOME.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT_CYCLES-1, mode becomes HOME the next cycle and the counter clears.
  - If control_pulse coincides with the terminal count, control_pulse wins: advance, no timeout.
- mode_leds is a registered one-hot decode of the next mode, so it always matches mode in the same cycle.

Optional Feature:
- Macro: MODE_TIMEOUT_EN.
- Defined: the idle counter and return-to-HOME behaviour are present.
- Undefined: the idle counter is not instantiated, TIMEOUT_CYCLES is ignored, and mode persists indefinitely until control_pulse or reset.

Decomposition:
- Shared header mode_select_defines.vh holds:
  - the MODE_* encodings and HOME;
  - the number of modes (5);
  - the one-hot LED mapping.
- One natural sub-module, hold_timer: saturating up-counter with clear, enable and a one-cycle terminal flag, parameterized by TIMER_W and LIMIT.
- Instantiate hold_timer twice: once for hold-to-reset, once for the idle timeout (the latter only under MODE_TIMEOUT_EN).

Test Plan (RESET_HOLD_CYCLES=8, TIMEOUT_CYCLES=20, MODE_TIMEOUT_EN defined):
- Reset then 5 control_pulses spaced 3 cycles apart -> mode goes 1,2,3,4,0,1; mode_leds stays one-hot matching each value.
- Mode 3, action_pulse at cycle t -> ff_pulse high only at t+1; other pulses 0. Repeat for modes 1, 2, 4 with next, rewind and display pulses.
- Mode 0, action_level high 7 cycles then low -> no soft_reset. Then high 12 cycles -> exactly one soft_reset, on the 8th held cycle.
- Mode 2 with no input for 20 cycles -> mode==1 on cycle 21. With a control_pulse on cycle 19 instead -> mode==3, no timeout.
- Mode 4, control_pulse and action_pulse in the same cycle -> display_pulse next cycle and mode==0.
- Force mode to 6 via a bench override -> mode==1 next cycle, no pulses. Assert reset mid-hold (count 5) -> counters cleared, mode==1, no soft_reset.
